deserializer_param: RTL and testbench

- Parametrised serial-to-parallel converter. Successor to the fixed 16-bit deserializer.
- Collects DATA_W qualified serial bits into one word. Bit order is selectable.
- Adds a flush input that emits a partial word together with a valid-bit count.
- Sits behind serial receive front-ends and feeds word-wide datapaths. There is no backpressure.

---
 rtl/deserializer_param.sv | 81 ++++++++
 tb/tb_deserializer_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer_param.sv
// Parametrised serial-to-parallel converter with selectable bit order and a flush that
// emits a justified partial word together with its valid-bit count.
module deserializer_param #(
   parameter int unsigned DATA_W    = 16,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned MOD_W     = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              data_i,
   input  logic              data_val_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [MOD_W-1:0]  deser_data_mod_o,
   output logic              deser_data_val_o
);

   logic [DATA_W-1:0] sr_q, sr_d, sr_acc, sr_cur;
   logic [DATA_W-1:0] data_q, data_d;
   logic [MOD_W-1:0]  cnt_q, cnt_d, n_bits;
   logic [MOD_W-1:0]  mod_q, mod_d;
   logic              val_q, val_d;
   logic              full;

   // The n collected bits sit at the shift-in end of sr; move them to the emission end.
   function automatic logic [DATA_W-1:0] justify(input logic [DATA_W-1:0] v,
                                                 input logic [MOD_W-1:0]  n);
      logic [MOD_W-1:0] sh;
      sh = MOD_W'(DATA_W) - n;
      return MSB_FIRST ? (v << sh) : (v >> sh);
   endfunction

   always_comb begin
      sr_acc = MSB_FIRST ? {sr_q[DATA_W-2:0], data_i} : {data_i, sr_q[DATA_W-1:1]};
      sr_cur = data_val_i ? sr_acc : sr_q;
      n_bits = data_val_i ? cnt_q + MOD_W'(1) : cnt_q;
      full   = data_val_i && (cnt_q == MOD_W'(DATA_W - 1));

      sr_d   = sr_cur;
      cnt_d  = n_bits;
      data_d = data_q;
      mod_d  = mod_q;
      val_d  = 1'b0;

      // A full word takes precedence so a coincident flush yields no extra empty word.
      if (full) begin
         data_d = sr_acc;
         mod_d  = MOD_W'(DATA_W);
         val_d  = 1'b1;
         sr_d   = '0;
         cnt_d  = '0;
      end else if (flush_i && (n_bits != '0)) begin
         data_d = justify(sr_cur, n_bits);
         mod_d  = n_bits;
         val_d  = 1'b1;
         sr_d   = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         mod_q  <= '0;
         val_q  <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         mod_q  <= mod_d;
         val_q  <= val_d;
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_mod_o = mod_q;
   assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer_param.sv
// Scoreboard bench: three instances (16/MSB, 16/LSB, 8/MSB) driven by directed vectors;
// expected words are queued at stimulus time and checked by one monitor on each strobe.
module tb_deserializer_param;

   typedef struct {
      logic [63:0] data;
      int          mod;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic srst;
   logic din   [3];
   logic dval  [3];
   logic dflush[3];

   logic [15:0] d0, d1;
   logic [7:0]  d2;
   logic [4:0]  m0, m1;
   logic [3:0]  m2;
   logic        v0, v1, v2;

   exp_t q0[$], q1[$], q2[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic chk_idle = 1'b0;
   logic chk_end  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   deserializer_param #(.DATA_W(16), .MSB_FIRST(1'b1)) u_16m (
      .clk_i(clk), .srst_i(srst), .data_i(din[0]), .data_val_i(dval[0]),
      .flush_i(dflush[0]), .deser_data_o(d0), .deser_data_mod_o(m0), .deser_data_val_o(v0));
   deserializer_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u_16l (
      .clk_i(clk), .srst_i(srst), .data_i(din[1]), .data_val_i(dval[1]),
      .flush_i(dflush[1]), .deser_data_o(d1), .deser_data_mod_o(m1), .deser_data_val_o(v1));
   deserializer_param #(.DATA_W(8), .MSB_FIRST(1'b1)) u_8m (
      .clk_i(clk), .srst_i(srst), .data_i(din[2]), .data_val_i(dval[2]),
      .flush_i(dflush[2]), .deser_data_o(d2), .deser_data_mod_o(m2), .deser_data_val_o(v2));

   // ---------------- monitor / checker ----------------
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_check(input int sel, input logic [63:0] d, input int m);
      exp_t e;
      int   sz;
      sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_strobe inst%0d: got data %0h mod %0d expected none",
                  sel, d, m);
      end else begin
         case (sel)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         cmp($sformatf("inst%0d_data", sel), d, e.data);
         cmp($sformatf("inst%0d_mod", sel), 64'(m), 64'(e.mod));
         cmp($sformatf("inst%0d_latency_cycle", sel), 64'(cyc), 64'(e.cyc));
      end
   endtask

   always @(negedge clk) begin
      if (chk_idle) begin
         cmp("rst_data0", 64'(d0), 64'h0);
         cmp("rst_mod0", 64'(m0), 64'h0);
         cmp("rst_val0", 64'(v0), 64'h0);
         cmp("rst_data1", 64'(d1), 64'h0);
         cmp("rst_mod1", 64'(m1), 64'h0);
         cmp("rst_val1", 64'(v1), 64'h0);
         cmp("rst_data2", 64'(d2), 64'h0);
         cmp("rst_mod2", 64'(m2), 64'h0);
         cmp("rst_val2", 64'(v2), 64'h0);
      end
      if (v0) pop_check(0, 64'(d0), int'(m0));
      if (v1) pop_check(1, 64'(d1), int'(m1));
      if (v2) pop_check(2, 64'(d2), int'(m2));
      if (chk_end) begin
         cmp("missing_strobes0", 64'(q0.size()), 64'h0);
         cmp("missing_strobes1", 64'(q1.size()), 64'h0);
         cmp("missing_strobes2", 64'(q2.size()), 64'h0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_word(input int sel, input logic [63:0] d, input int m);
      exp_t e;
      e.data = d;
      e.mod  = m;
      e.cyc  = cyc + 1;
      case (sel)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic step(input int sel, input logic v, input logic d, input logic f,
                       input logic r);
      for (int i = 0; i < 3; i++) begin
         din[i]    = 1'b1;
         dval[i]   = 1'b0;
         dflush[i] = 1'b0;
      end
      srst = r;
      if (sel >= 0 && sel < 3) begin
         din[sel]    = d;
         dval[sel]   = v;
         dflush[sel] = f;
      end
      @(posedge clk);
      #1;
   endtask

   // Sends the low n bits of w, most significant of them first.
   task automatic send_bits(input int sel, input logic [63:0] w, input int n,
                            input bit flush_last, input bit do_exp,
                            input logic [63:0] ed, input int em);
      for (int i = n - 1; i >= 0; i--) begin
         if (i == 0 && do_exp) expect_word(sel, ed, em);
         step(sel, 1'b1, w[i], flush_last && (i == 0), 1'b0);
      end
   endtask

   initial begin
      step(-1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(-1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_idle = 1'b1;
      @(negedge clk);
      #1;
      chk_idle = 1'b0;
      step(-1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 16 ones, MSB first
      send_bits(0, 64'hFFFF, 16, 1'b0, 1'b1, 64'hFFFF, 16);
      step(-1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 4 zeros, 4 idle cycles with data_i=1, 12 zeros
      send_bits(0, 64'h0, 4, 1'b0, 1'b0, 64'h0, 0);
      repeat (4) step(0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_bits(0, 64'h0, 12, 1'b0, 1'b1, 64'h0000, 16);
      step(-1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 1,0,1,1 then flush: left-justified (MSB first) and right-justified (LSB first)
      send_bits(0, 64'hB, 4, 1'b0, 1'b0, 64'h0, 0);
      expect_word(0, 64'hB000, 4);
      step(0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_bits(1, 64'hB, 4, 1'b0, 1'b0, 64'h0, 0);
      expect_word(1, 64'h000D, 4);
      step(1, 1'b0, 1'b1, 1'b1, 1'b0);

      // LSB first: 1,1 then 0 accepted on the flush edge -> 3 bits, value 3
      send_bits(1, 64'h6, 3, 1'b1, 1'b1, 64'h0003, 3);
      step(-1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 8-bit back-to-back words
      send_bits(2, 64'hA5, 8, 1'b0, 1'b1, 64'hA5, 8);
      send_bits(2, 64'h3C, 8, 1'b0, 1'b1, 64'h3C, 8);

      // Flush coinciding with the 8th bit, then flush with nothing collected
      send_bits(2, 64'h5A, 8, 1'b1, 1'b1, 64'h5A, 8);
      step(2, 1'b0, 1'b1, 1'b1, 1'b0);
      step(-1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset aborts a partial word, then a full 16'h1234
      send_bits(0, 64'h1F, 5, 1'b0, 1'b0, 64'h0, 0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_bits(0, 64'h1234, 16, 1'b0, 1'b1, 64'h1234, 16);

      repeat (4) step(-1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_end = 1'b1;
      @(negedge clk);
      #1;
      chk_end = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
